// File: rtl/return_addr_stack.sv
// Return address stack for the fetch-stage branch predictor.
// Calls push the return address, returns pop the predicted target. The
// storage is a circular buffer, so overflow silently drops the oldest entry.

package len5_config_pkg;
  localparam int unsigned RAS_DEPTH = 8;
endpackage

module return_addr_stack #(
  parameter int unsigned DEPTH = len5_config_pkg::RAS_DEPTH,
  parameter int unsigned ALEN  = 64
) (
  input  logic            clk_i,
  input  logic            rst_ni,
  input  logic            flush_i,
  input  logic            push_i,
  input  logic [ALEN-1:0] push_addr_i,
  input  logic            pop_i,
  output logic            top_valid_o,
  output logic [ALEN-1:0] top_addr_o,
  output logic            full_o
);

  localparam int unsigned PTR_W = $clog2(DEPTH);
  localparam logic [PTR_W:0] CNT_FULL = (PTR_W + 1)'(DEPTH);

  logic [ALEN-1:0]  mem [DEPTH];
  logic [PTR_W-1:0] tos_q;
  logic [PTR_W:0]   cnt_q;
  logic [PTR_W-1:0] top_idx;
  logic             empty;
  logic             swap;

  assign top_idx = tos_q - PTR_W'(1);
  assign empty   = (cnt_q == '0);
  // A push+pop on an empty stack has nothing to replace, so it acts as a push.
  assign swap    = push_i & pop_i & ~empty;

  // Pointer and occupancy update; flush only clears the count.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      tos_q <= '0;
      cnt_q <= '0;
    end else if (flush_i) begin
      cnt_q <= '0;
    end else if (swap) begin
      tos_q <= tos_q;
    end else if (push_i) begin
      tos_q <= tos_q + PTR_W'(1);
      if (cnt_q != CNT_FULL) cnt_q <= cnt_q + (PTR_W + 1)'(1);
    end else if (pop_i && !empty) begin
      tos_q <= tos_q - PTR_W'(1);
      cnt_q <= cnt_q - (PTR_W + 1)'(1);
    end
  end

  // Entry storage: swap overwrites the current top, push writes the free slot.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      for (int i = 0; i < int'(DEPTH); i++) mem[i] <= '0;
    end else if (!flush_i && push_i) begin
      if (swap) mem[top_idx] <= push_addr_i;
      else      mem[tos_q]   <= push_addr_i;
    end
  end

  // Zero-latency prediction outputs straight from the registers.
  always_comb begin
    top_addr_o  = mem[top_idx];
    top_valid_o = ~empty;
    full_o      = (cnt_q == CNT_FULL);
  end

endmodule

// File: tb/tb_return_addr_stack.sv
// Randomized and directed bench for return_addr_stack against a queue model.
module tb_return_addr_stack;

  localparam int DEPTH = 8;
  localparam int ALEN  = 64;

  logic            clk_i = 1'b0;
  logic            rst_ni;
  logic            flush_i;
  logic            push_i;
  logic [ALEN-1:0] push_addr_i;
  logic            pop_i;
  logic            top_valid_o;
  logic [ALEN-1:0] top_addr_o;
  logic            full_o;

  int nchecks = 0;
  int nerrors = 0;

  logic [ALEN-1:0] q [$];

  return_addr_stack #(.DEPTH(DEPTH), .ALEN(ALEN)) dut (
    .clk_i       (clk_i),
    .rst_ni      (rst_ni),
    .flush_i     (flush_i),
    .push_i      (push_i),
    .push_addr_i (push_addr_i),
    .pop_i       (pop_i),
    .top_valid_o (top_valid_o),
    .top_addr_o  (top_addr_o),
    .full_o      (full_o)
  );

  always #5 clk_i = ~clk_i;

  task automatic check(input string tag, input logic [ALEN-1:0] got, input logic [ALEN-1:0] exp);
    nchecks++;
    if (got !== exp) begin
      nerrors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // Stack semantics: back of the queue is the top, at most DEPTH entries kept.
  task automatic model_apply(input logic f, input logic pu, input logic [ALEN-1:0] a, input logic po);
    if (f) q.delete();
    else if (pu && po && q.size() != 0) q[q.size()-1] = a;
    else if (pu) begin
      q.push_back(a);
      if (q.size() > DEPTH) void'(q.pop_front());
    end else if (po && q.size() != 0) void'(q.pop_back());
  endtask

  task automatic compare_model(input string tag);
    check({tag, "_valid"}, {63'd0, top_valid_o}, {63'd0, q.size() != 0});
    check({tag, "_full"},  {63'd0, full_o},      {63'd0, q.size() == DEPTH});
    if (q.size() != 0) check({tag, "_top"}, top_addr_o, q[q.size()-1]);
  endtask

  task automatic step(input logic f, input logic pu, input logic po, input logic [ALEN-1:0] a);
    @(negedge clk_i);
    compare_model("model");
    flush_i = f; push_i = pu; pop_i = po; push_addr_i = a;
    @(posedge clk_i);
    model_apply(f, pu, a, po);
    #1;
    flush_i = 1'b0; push_i = 1'b0; pop_i = 1'b0; push_addr_i = '0;
  endtask

  task automatic expect_out(input string tag, input logic v, input logic fu, input logic [ALEN-1:0] t);
    #1;
    check({tag, "_valid"}, {63'd0, top_valid_o}, {63'd0, v});
    check({tag, "_full"},  {63'd0, full_o},      {63'd0, fu});
    if (v) check({tag, "_top"}, top_addr_o, t);
  endtask

  initial begin
    rst_ni = 1'b0; flush_i = 1'b0; push_i = 1'b0; pop_i = 1'b0; push_addr_i = '0;
    #2;
    check("rst_valid", {63'd0, top_valid_o}, 64'd0);
    check("rst_full",  {63'd0, full_o},      64'd0);
    check("rst_top",   top_addr_o,           64'd0);
    #10 rst_ni = 1'b1;

    // LIFO order
    step(0, 1, 0, 64'h1000);
    step(0, 1, 0, 64'h2000);
    step(0, 1, 0, 64'h3000);
    expect_out("lifo_pop1", 1, 0, 64'h3000);
    step(0, 0, 1, '0);
    expect_out("lifo_pop2", 1, 0, 64'h2000);
    step(0, 0, 1, '0);
    expect_out("lifo_pop3", 1, 0, 64'h1000);
    step(0, 0, 1, '0);
    expect_out("lifo_empty", 0, 0, '0);

    // Overflow drops the oldest entry
    for (int i = 1; i <= 9; i++) begin
      step(0, 1, 0, 64'(i * 'h100));
      if (i >= 8) expect_out("ovf_full", 1, 1, 64'(i * 'h100));
    end
    for (int i = 9; i >= 2; i--) begin
      expect_out("ovf_pop", 1, i == 9, 64'(i * 'h100));
      step(0, 0, 1, '0);
    end
    expect_out("ovf_empty", 0, 0, '0);

    // Underflow is ignored
    step(0, 0, 1, '0);
    step(0, 0, 1, '0);
    expect_out("udf_empty", 0, 0, '0);
    step(0, 1, 0, 64'hABC);
    expect_out("udf_push", 1, 0, 64'hABC);
    step(0, 0, 1, '0);

    // Coroutine swap
    step(0, 1, 0, 64'h10);
    step(0, 1, 0, 64'h20);
    step(0, 1, 1, 64'h30);
    expect_out("swap_top", 1, 0, 64'h30);
    step(0, 0, 1, '0);
    expect_out("swap_next", 1, 0, 64'h10);
    step(0, 0, 1, '0);
    expect_out("swap_drained", 0, 0, '0);
    step(0, 1, 1, 64'h44);
    expect_out("swap_empty", 1, 0, 64'h44);
    step(0, 0, 1, '0);
    expect_out("swap_empty_pop", 0, 0, '0);

    // Flush wins over a simultaneous push
    for (int i = 0; i < 5; i++) step(0, 1, 0, 64'($urandom));
    step(1, 1, 0, 64'h55);
    expect_out("flush", 0, 0, '0);
    step(0, 1, 0, 64'h66);
    expect_out("flush_push", 1, 0, 64'h66);
    step(0, 0, 1, '0);
    expect_out("flush_pop", 0, 0, '0);

    // Asynchronous reset between edges
    step(0, 1, 0, 64'h1);
    step(0, 1, 0, 64'h2);
    step(0, 1, 0, 64'h3);
    #2 rst_ni = 1'b0;
    #1;
    check("arst_valid", {63'd0, top_valid_o}, 64'd0);
    check("arst_full",  {63'd0, full_o},      64'd0);
    check("arst_top",   top_addr_o,           64'd0);
    q.delete();
    #13 rst_ni = 1'b1;
    step(0, 1, 0, 64'h77);
    expect_out("arst_push", 1, 0, 64'h77);
    step(0, 0, 1, '0);
    expect_out("arst_pop", 0, 0, '0);

    // Randomized traffic against the model
    for (int n = 0; n < 3000; n++) begin
      int r;
      logic f, pu, po;
      r  = int'($urandom_range(99));
      f  = (r < 4);
      pu = ($urandom_range(99) < 50);
      po = ($urandom_range(99) < 45);
      step(f, pu, po, {$urandom, $urandom});
    end
    @(negedge clk_i);
    compare_model("final");

    $display("Simulation finished: %0d checks, %0d errors", nchecks, nerrors);
    $finish;
  end

endmodule
